// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction-fetch initiator for the single-cycle core. Holds the program
// counter, drives the word address into a combinational instruction ROM,
// captures the returned word and presents it to decode over a valid/ready
// handshake. Branch/jump redirects reload the PC. Fetch stops when the halt
// word is read or the PC leaves the ROM window.
//
// Parameters:
//   ADDR_W     ROM word-address width (ROM holds 2**ADDR_W words)
//   RESET_PC   byte address loaded into the PC on reset (aligned down)
//   HALT_WORD  instruction encoding that terminates fetch
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   synchronous active-low reset
//   rom_addr        out  word address to the ROM (pc[ADDR_W+1:2])
//   rom_instr       in   ROM read data, same cycle
//   redirect_valid  in   load a new PC this cycle
//   redirect_pc     in   byte target of the redirect (aligned down)
//   out_valid       out  out_instr/out_pc hold a valid instruction
//   out_ready       in   decode accepts the presented instruction
//   out_instr       out  fetched instruction word
//   out_pc          out  byte address of out_instr
//   fetch_count     out  transfer counter (only with FETCH_COUNT_EN)
//   halted          out  fetch stopped
//
// Optional feature: define FETCH_COUNT_EN to add the 32-bit fetch_count
// output, which counts every accepted transfer and wraps modulo 2**32.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int          ADDR_W    = 5,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_instr,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc,
`ifdef FETCH_COUNT_EN
   output logic [31:0]       fetch_count,
`endif
   output logic              halted
);

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] HALT = 1'b1;

   localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;
   localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

   logic [0:0]  state;
   logic [31:0] pc;
   logic        in_range;
   logic        take;
   logic        fetch_ok;

   assign rom_addr = pc[ADDR_W+1:2];

   // Anything above the ROM window (including a wrap past 2**32) is out of
   // range; the ROM itself would silently alias, so catch it here.
   assign in_range = (pc[31:ADDR_W+2] == '0);

   // The output register may be (re)loaded when it is empty or being drained.
   assign take     = (state == RUN) && (!out_valid || out_ready);
   assign fetch_ok = in_range && (rom_instr != HALT_WORD);

   assign halted   = (state == HALT);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc        <= RESET_PC_ALIGNED;
         out_valid <= 1'b0;
         out_instr <= '0;
         out_pc    <= '0;
         state     <= RUN;
      end else if (redirect_valid) begin
         // Flush: any held instruction is dropped (or was just accepted if
         // out_ready was high); fetch resumes from the new PC next cycle.
         pc        <= redirect_pc & ALIGN_MASK;
         out_valid <= 1'b0;
         state     <= RUN;
      end else if (take) begin
         if (fetch_ok) begin
            out_instr <= rom_instr;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + 32'd4;
         end else begin
            // pc keeps the offending address for debug visibility.
            out_valid <= 1'b0;
            state     <= HALT;
         end
      end
   end

`ifdef FETCH_COUNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_count <= '0;
      end else if (out_valid && out_ready) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit: a directed vector table, a few
// hand-written multi-cycle sequences (backpressure, redirect flush, reset
// mid-stream) and a randomized phase compared against a behavioural model.
// Define FETCH_COUNT_EN to also check the transfer counter.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam int          ADDR_W    = 5;
   localparam int          ROM_WORDS = 1 << ADDR_W;
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_instr;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [31:0]       out_pc;
   logic              halted;
`ifdef FETCH_COUNT_EN
   logic [31:0]       fetch_count;
`endif

   logic [31:0] rom_mem [ROM_WORDS];
   logic [31:0] prog    [12];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign rom_instr = rom_mem[rom_addr];

   instr_fetch_unit #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (32'h0000_0000),
      .HALT_WORD(HALT_WORD)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rom_addr      (rom_addr),
      .rom_instr     (rom_instr),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
`ifdef FETCH_COUNT_EN
      .fetch_count   (fetch_count),
`endif
      .halted        (halted)
   );

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
      rst_n          = r;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
   endtask

   // Advance one edge and settle 1 time unit after it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_program();
      prog[0]  = 32'h0080_0293;  // addi x5,x0,8
      prog[1]  = 32'h00f0_0313;  // addi x6,x0,15
      prog[2]  = 32'h0062_a023;  // sw   x6,0(x5)
      prog[3]  = 32'h0053_03b3;  // add  x7,x6,x5
      prog[4]  = 32'h0072_a223;  // sw   x7,4(x5)
      prog[5]  = 32'h03c3_84b3;
      prog[6]  = 32'h0092_a423;  // sw   x9,8(x5)
      prog[7]  = 32'h0014_8493;  // addi x9,x9,1
      prog[8]  = 32'h0000_0013;  // nop
      prog[9]  = 32'h0000_0013;  // nop
      prog[10] = 32'h0122_a023;  // sw   x18,0(x5)
      prog[11] = HALT_WORD;
      for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = (i < 12) ? prog[i] : 32'h0;
   endtask

   // ------------------------------------------------------ reference model
   // Tracks what decode should see: the instruction currently on offer, the
   // next byte address to read, whether fetch has stopped, and how many
   // instructions have been handed over.
   logic [31:0] m_next_pc;
   logic        m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic        m_stopped;
   logic [31:0] m_count;

   task automatic model_step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
      logic [31:0] word;
      if (!r) begin
         m_next_pc = 32'h0;
         m_valid   = 1'b0;
         m_instr   = 32'h0;
         m_pc      = 32'h0;
         m_stopped = 1'b0;
         m_count   = 32'h0;
      end else begin
         if (m_valid && rdy) m_count = m_count + 1;
         if (rv) begin
            m_next_pc = rpc - (rpc % 4);
            m_valid   = 1'b0;
            m_stopped = 1'b0;
         end else if (!m_stopped && (!m_valid || rdy)) begin
            if (m_next_pc >= ROM_WORDS * 4) begin
               m_valid   = 1'b0;
               m_stopped = 1'b1;
            end else begin
               word = rom_mem[m_next_pc / 4];
               if (word == HALT_WORD) begin
                  m_valid   = 1'b0;
                  m_stopped = 1'b1;
               end else begin
                  m_valid   = 1'b1;
                  m_instr   = word;
                  m_pc      = m_next_pc;
                  m_next_pc = m_next_pc + 4;
               end
            end
         end
      end
   endtask

   // ---------------------------------------------------------- vector table
   typedef struct {
      logic        rst_n;
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        exp_valid;
      logic        exp_halted;
      logic        chk_data;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                          input logic ev, input logic eh, input logic cd,
                          input logic [31:0] ei, input logic [31:0] ep);
      vec_t v;
      v.rst_n = r;  v.ready = rdy;  v.redir = rv;  v.rpc = rpc;
      v.exp_valid = ev;  v.exp_halted = eh;  v.chk_data = cd;
      v.exp_instr = ei;  v.exp_pc = ep;
      vecs.push_back(v);
   endtask

   // ----------------------------------------------------------------- test
   initial begin
      int n_valid;
      bit reached;

      load_program();
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      m_next_pc = 0; m_valid = 0; m_instr = 0; m_pc = 0; m_stopped = 0; m_count = 0;

      // Reset, full program run to the halt word, then redirects.
      add_vec(0, 1, 0, 32'h0, 0, 0, 1, 32'h0, 32'h0);
      for (int i = 0; i < 11; i++) add_vec(1, 1, 0, 32'h0, 1, 0, 1, prog[i], 32'(4 * i));
      add_vec(1, 1, 0, 32'h0,  0, 1, 0, 32'h0, 32'h0);     // halt word seen
      add_vec(1, 0, 0, 32'h0,  0, 1, 0, 32'h0, 32'h0);     // stays halted
      add_vec(1, 1, 1, 32'h80, 0, 0, 0, 32'h0, 32'h0);     // redirect out of ROM
      add_vec(1, 1, 0, 32'h0,  0, 1, 0, 32'h0, 32'h0);     // caught by range check
      add_vec(1, 1, 0, 32'h0,  0, 1, 0, 32'h0, 32'h0);
      add_vec(1, 1, 1, 32'h0,  0, 0, 0, 32'h0, 32'h0);     // redirect back
      add_vec(1, 1, 0, 32'h0,  1, 0, 1, prog[0], 32'h0);
      add_vec(1, 1, 0, 32'h0,  1, 0, 1, prog[1], 32'h4);
      add_vec(0, 1, 0, 32'h0,  0, 0, 1, 32'h0, 32'h0);     // reset mid-stream

      foreach (vecs[k]) begin
         drive(vecs[k].rst_n, vecs[k].ready, vecs[k].redir, vecs[k].rpc);
         tick();
         check($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'(vecs[k].exp_valid));
         check($sformatf("vec%0d halted", k), 32'(halted), 32'(vecs[k].exp_halted));
         if (vecs[k].chk_data) begin
            check($sformatf("vec%0d out_instr", k), out_instr, vecs[k].exp_instr);
            check($sformatf("vec%0d out_pc", k), out_pc, vecs[k].exp_pc);
         end
      end

      // ---- Backpressure: hold 0x08 for three cycles.
      drive(0, 1, 0, 32'h0); tick();
      drive(1, 1, 0, 32'h0); tick(); tick(); tick();
      check("bp presented pc", out_pc, 32'h8);
      drive(1, 0, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp hold valid", 32'(out_valid), 32'd1);
         check("bp hold instr", out_instr, 32'h0062_a023);
         check("bp hold pc", out_pc, 32'h8);
         check("bp hold rom_addr", 32'(rom_addr), 32'd3);
      end
      drive(1, 1, 0, 32'h0); tick();
      check("bp resume instr", out_instr, 32'h0053_03b3);
      check("bp resume pc", out_pc, 32'hC);

      // ---- Redirect to a misaligned target while output is stalled.
      drive(0, 1, 0, 32'h0); tick();
      drive(1, 1, 0, 32'h0); tick();
      drive(1, 0, 1, 32'h17); tick();
      check("redir flush valid", 32'(out_valid), 32'd0);
      check("redir rom_addr", 32'(rom_addr), 32'd5);
      drive(1, 1, 0, 32'h0); tick();
      check("redir target valid", 32'(out_valid), 32'd1);
      check("redir target instr", out_instr, 32'h03c3_84b3);
      check("redir target pc", out_pc, 32'h14);

      // ---- Reset mid-stream at pc=0x18, then run to halt counting transfers.
      drive(0, 1, 0, 32'h0); tick();
      drive(1, 1, 0, 32'h0);
      reached = 0;
      for (int i = 0; i < 20 && !reached; i++) begin
         tick();
         if (rom_addr == 5'd6) reached = 1;
      end
      check("mid reach pc 0x18", 32'(reached), 32'd1);
      drive(0, 1, 0, 32'h0); tick();
      check("mid reset valid", 32'(out_valid), 32'd0);
      check("mid reset halted", 32'(halted), 32'd0);
`ifdef FETCH_COUNT_EN
      check("count after reset", fetch_count, 32'd0);
`endif
      drive(1, 1, 0, 32'h0); tick();
      check("restart instr", out_instr, 32'h0080_0293);
      check("restart pc", out_pc, 32'h0);
      n_valid = 1;
      reached = 0;
      for (int i = 0; i < 40 && !reached; i++) begin
         tick();
         if (halted) reached = 1;
         else if (out_valid) n_valid++;
      end
      check("run reaches halt", 32'(reached), 32'd1);
      check("instructions presented", 32'(n_valid), 32'd11);
`ifdef FETCH_COUNT_EN
      check("count at halt", fetch_count, 32'd11);
`endif

      // ---- Randomized phase against the model.
      for (int i = 0; i < ROM_WORDS; i++)
         rom_mem[i] = ($urandom_range(0, 9) == 0) ? HALT_WORD : $urandom();
      drive(0, 1, 0, 32'h0); tick();
      model_step(0, 1, 0, 32'h0);
      for (int c = 0; c < 600; c++) begin
         logic        r, rdy, rv;
         logic [31:0] rpc;
         r   = ($urandom_range(0, 59) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 11) == 0);
         rpc = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 150));
         drive(r, rdy, rv, rpc);
         tick();
         model_step(r, rdy, rv, rpc);
         check("rnd out_valid", 32'(out_valid), 32'(m_valid));
         check("rnd halted", 32'(halted), 32'(m_stopped));
         check("rnd rom_addr", 32'(rom_addr), (m_next_pc / 4) % ROM_WORDS);
         if (m_valid) begin
            check("rnd out_instr", out_instr, m_instr);
            check("rnd out_pc", out_pc, m_pc);
         end
`ifdef FETCH_COUNT_EN
         check("rnd fetch_count", fetch_count, m_count);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
